// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_tx_pkg
// Description : UART frame constants and the transmit FSM state encoding.
//               The RX side imports the same package for its frame levels.
// Revision    : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

  // Transmit FSM states, in frame order
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Width-bit LSB-first shift register with a data bit counter.
//               load  : capture data and clear the counter
//               shift : move the next bit into position 0 and count it
//               done  : the bit in position 0 is the last data bit
// Ports       : clk, rst (sync, active high), load, shift, data[Width-1:0],
//               bit_out (current bit), next_bit (bit after a shift), done
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [Width-1:0] data,
  output logic             bit_out,
  output logic             next_bit,
  output logic             done
);

  // A 1-bit frame still needs a 1-bit counter
  localparam int CNT_W = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(Width - 1);

  logic [Width-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_shift <= data;
      r_cnt   <= '0;
    end else if (shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_out = r_shift[0];
  assign done    = (r_cnt == LAST_IDX);

  // The FSM registers the line one cycle ahead, so it needs the bit that
  // will sit in position 0 after the shift happening on the same edge.
  generate
    if (Width > 1) begin : g_next_wide
      assign next_bit = r_shift[1];
    end else begin : g_next_narrow
      assign next_bit = 1'b0;
    end
  endgenerate

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_ctrl
// Description : UART transmit framing controller. Accepts a word on a
//               valid/busy handshake and sends start, Width data bits
//               LSB-first, optional parity, stop. One bit per CLK.
// Config      : UART_TX_TWO_STOP_EN - two stop cycles instead of one
// Ports       : CLK, RST (sync, active high), P_DATA[Width-1:0], Data_Valid,
//               PAR_EN, par_bit (from parity calculator),
//               TX_OUT (registered line, idle high), Busy (registered)
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             par_bit,
  output logic             TX_OUT,
  output logic             Busy
);

  tx_state_e r_state;
  logic      r_par_en;
`ifdef UART_TX_TWO_STOP_EN
  logic      r_stop_second;
`endif

  logic w_load;
  logic w_shift;
  logic w_bit_out;
  logic w_next_bit;
  logic w_done;

  // Busy is low only in IDLE, so this is the Data_Valid && !Busy handshake
  assign w_load  = (r_state == IDLE) && Data_Valid;
  assign w_shift = (r_state == DATA) && !w_done;

  uart_tx_serializer #(
    .Width (Width)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (w_load),
    .shift    (w_shift),
    .data     (P_DATA),
    .bit_out  (w_bit_out),
    .next_bit (w_next_bit),
    .done     (w_done)
  );

  // TX_OUT is registered: every transition loads the level for the state
  // being entered, so the line always reflects the current state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_par_en      <= 1'b0;
      TX_OUT        <= IDLE_LEVEL;
      Busy          <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop_second <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (Data_Valid) begin
            r_state  <= START;
            r_par_en <= PAR_EN;
            TX_OUT   <= START_BIT;
            Busy     <= 1'b1;
          end
        end
        START: begin
          r_state <= DATA;
          TX_OUT  <= w_bit_out;
        end
        DATA: begin
          if (w_done) begin
            if (r_par_en) begin
              r_state <= PARITY;
              TX_OUT  <= par_bit;
            end else begin
              r_state <= STOP;
              TX_OUT  <= STOP_BIT;
            end
          end else begin
            TX_OUT <= w_next_bit;
          end
        end
        PARITY: begin
          r_state <= STOP;
          TX_OUT  <= STOP_BIT;
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (!r_stop_second) begin
            r_stop_second <= 1'b1;
          end else begin
            r_stop_second <= 1'b0;
            r_state       <= IDLE;
            TX_OUT        <= IDLE_LEVEL;
            Busy          <= 1'b0;
          end
`else
          r_state <= IDLE;
          TX_OUT  <= IDLE_LEVEL;
          Busy    <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
          TX_OUT  <= IDLE_LEVEL;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx_frame_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame_ctrl
// Description : Self-checking bench for uart_tx_frame_ctrl (Width = 8).
//               Expected line/Busy levels per cycle are queued when a word is
//               offered and popped on each falling edge. Includes a model of
//               the registered parity calculator that feeds par_bit.
// Config      : UART_TX_TWO_STOP_EN selects the two-stop-cycle expectation
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;

  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYPE = 1'b0;
  logic         par_bit;
  logic         TX_OUT;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(
    .Width (W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Parity calculator model: captures the word on acceptance, registers parity
  logic [W-1:0] draft = '0;
  always @(posedge CLK) begin
    if (Data_Valid && !Busy) draft <= P_DATA;
    par_bit <= PAR_TYPE ? ~^draft : ^draft;
  end

  // Queue the per-cycle expectation of one frame plus the idle cycle after it
  function automatic void push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
    exp_q.push_back('{tx: 1'b0, busy: 1'b1});
    for (int i = 0; i < W; i++) exp_q.push_back('{tx: d[i], busy: 1'b1});
    if (pe) exp_q.push_back('{tx: (pt ? ~^d : ^d), busy: 1'b1});
    for (int i = 0; i < NSTOP; i++) exp_q.push_back('{tx: 1'b1, busy: 1'b1});
    exp_q.push_back('{tx: 1'b1, busy: 1'b0});
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    Data_Valid = 1'b1;
    P_DATA = 8'hC3;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
    Data_Valid = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_parity_frame();
    int idx = 0;
    int busy_cycles = 0;
    exp_t e;
    PAR_TYPE = 1'b0;
    PAR_EN = 1'b1;
    P_DATA = 8'hA5;
    Data_Valid = 1'b1;
    push_frame(8'hA5, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      e = exp_q.pop_front();
      if (Busy === 1'b1) busy_cycles++;
      checks++;
      if (TX_OUT !== e.tx || Busy !== e.busy) begin
        errors++;
        $display("FAIL parity_frame cycle %0d: TX_OUT=%b Busy=%b, required %b %b", idx, TX_OUT, Busy, e.tx, e.busy);
      end
      idx++;
    end
    checks++;
    if (busy_cycles != 10 + NSTOP) begin
      errors++;
      $display("FAIL parity_busy_len: %0d cycles, required %0d", busy_cycles, 10 + NSTOP);
    end
  endtask

  task automatic test_no_parity();
    int idx = 0;
    int busy_cycles = 0;
    exp_t e;
    PAR_EN = 1'b0;
    P_DATA = 8'h01;
    Data_Valid = 1'b1;
    push_frame(8'h01, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      e = exp_q.pop_front();
      if (Busy === 1'b1) busy_cycles++;
      checks++;
      if (TX_OUT !== e.tx || Busy !== e.busy) begin
        errors++;
        $display("FAIL no_parity cycle %0d: TX_OUT=%b Busy=%b, required %b %b", idx, TX_OUT, Busy, e.tx, e.busy);
      end
      idx++;
    end
    checks++;
    if (busy_cycles != 9 + NSTOP) begin
      errors++;
      $display("FAIL no_parity_busy_len: %0d cycles, required %0d", busy_cycles, 9 + NSTOP);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int drop_at;
    exp_t e;
    PAR_EN = 1'b0;
    P_DATA = 8'hFF;
    Data_Valid = 1'b1;
    push_frame(8'hFF, 1'b0, 1'b0);
    drop_at = exp_q.size();          // first cycle of the second frame
    push_frame(8'h00, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (TX_OUT !== e.tx || Busy !== e.busy) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: TX_OUT=%b Busy=%b, required %b %b", idx, TX_OUT, Busy, e.tx, e.busy);
      end
      if (idx == 0) P_DATA = 8'h00;  // offered while busy, used for frame two
      if (idx == drop_at) Data_Valid = 1'b0;
      idx++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int idx = 0;
    exp_t e;
    PAR_EN = 1'b0;
    P_DATA = 8'h3C;
    Data_Valid = 1'b1;
    // Cycles 0..4 are start and data bits 0..3; reset is raised during bit 3
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
    end
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre bit3: TX_OUT=%b Busy=%b, required 1 1", TX_OUT, Busy);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: TX_OUT=%b Busy=%b, required 1 0", TX_OUT, Busy);
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resume: TX_OUT=%b Busy=%b, required 1 0", TX_OUT, Busy);
    end
    P_DATA = 8'h96;
    PAR_EN = 1'b1;
    Data_Valid = 1'b1;
    push_frame(8'h96, 1'b1, PAR_TYPE);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (TX_OUT !== e.tx || Busy !== e.busy) begin
        errors++;
        $display("FAIL after_abort cycle %0d: TX_OUT=%b Busy=%b, required %b %b", idx, TX_OUT, Busy, e.tx, e.busy);
      end
      idx++;
    end
  endtask

  task automatic test_odd_parity_mid_changes();
    int idx = 0;
    exp_t e;
    PAR_TYPE = 1'b1;
    PAR_EN = 1'b1;
    P_DATA = 8'h07;
    Data_Valid = 1'b1;
    push_frame(8'h07, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (TX_OUT !== e.tx || Busy !== e.busy) begin
        errors++;
        $display("FAIL odd_parity cycle %0d: TX_OUT=%b Busy=%b, required %b %b", idx, TX_OUT, Busy, e.tx, e.busy);
      end
      if (idx == 9) begin
        checks++;
        if (TX_OUT !== 1'b0) begin
          errors++;
          $display("FAIL odd_parity_bit: TX_OUT=%b, required 0", TX_OUT);
        end
      end
      if (idx == 2) P_DATA = 8'hF8;
      if (idx == 4) PAR_EN = 1'b0;
      idx++;
    end
    PAR_TYPE = 1'b0;
  endtask

  task automatic test_stop_length();
    int idx = 0;
    int busy_cycles = 0;
    exp_t e;
    PAR_EN = 1'b1;
    P_DATA = 8'h55;
    Data_Valid = 1'b1;
    push_frame(8'h55, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      e = exp_q.pop_front();
      if (Busy === 1'b1) busy_cycles++;
      checks++;
      if (TX_OUT !== e.tx || Busy !== e.busy) begin
        errors++;
        $display("FAIL stop_len cycle %0d: TX_OUT=%b Busy=%b, required %b %b", idx, TX_OUT, Busy, e.tx, e.busy);
      end
      idx++;
    end
    checks++;
    if (busy_cycles != 10 + NSTOP) begin
      errors++;
      $display("FAIL stop_busy_len: %0d cycles, required %0d", busy_cycles, 10 + NSTOP);
    end
  endtask

  initial begin
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_odd_parity_mid_changes();
    test_stop_length();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_frame_ctrl
`default_nettype wire
